// File: rtl/steer_en_sm.sv
// Steering-enable state machine: qualifies rider presence and balance from the
// captured left/right load-cell readings before the balance controller may steer.
module steer_en_sm #(
  parameter int          FAST_SIM     = 0,
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        ld_vld,
  output logic        en_steer,
  output logic        rider_off
);

  localparam int          DATA_W = 12;
  localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] WAIT     = 2'b01;
  localparam logic [1:0] STEER_EN = 2'b10;

  // Magnitude of a 13-bit signed difference of two 12-bit unsigned values
  // always fits back into 12 bits.
  function automatic logic [DATA_W-1:0] abs_diff_f(input logic signed [DATA_W:0] d);
    logic signed [DATA_W:0] n;
    n = -d;
    return d[DATA_W] ? n[DATA_W-1:0] : d[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0]        lft_q;
  logic [DATA_W-1:0]        rght_q;
  logic [1:0]               state;
  logic [1:0]               nxt_state;
  logic [25:0]              tmr;
  logic                     clr_tmr;
  logic                     inc_tmr;
  logic                     tmr_full;
  logic [DATA_W:0]          sum;
  logic signed [DATA_W:0]   diff;
  logic [DATA_W-1:0]        abs_diff;
  logic                     sum_gt_min;
  logic                     sum_lt_min;
  logic                     diff_gt_1_4;
  logic                     diff_gt_15_16;

  // Evaluation stage: everything below works from the captured sample only.
  assign sum           = {1'b0, lft_q} + {1'b0, rght_q};
  assign diff          = $signed({1'b0, lft_q}) - $signed({1'b0, rght_q});
  assign abs_diff      = abs_diff_f(diff);
  assign sum_gt_min    = (sum > ON_THR);
  assign sum_lt_min    = (sum < OFF_THR);
  assign diff_gt_1_4   = ({1'b0, abs_diff} > (sum >> 2));
  assign diff_gt_15_16 = ({1'b0, abs_diff} > (sum - (sum >> 4)));
  assign tmr_full      = (FAST_SIM != 0) ? (&tmr[14:0]) : (&tmr);

  always_comb begin
    nxt_state = state;
    clr_tmr   = 1'b0;
    inc_tmr   = 1'b0;
    case (state)
      IDLE: begin
        if (sum_gt_min) begin
          nxt_state = WAIT;
          clr_tmr   = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_min)       nxt_state = IDLE;
        else if (diff_gt_1_4) clr_tmr   = 1'b1;
        else if (tmr_full)    nxt_state = STEER_EN;
        else                  inc_tmr   = 1'b1;
      end
      STEER_EN: begin
        if (sum_lt_min) nxt_state = IDLE;
        else if (diff_gt_15_16) begin
          nxt_state = WAIT;
          clr_tmr   = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Register stage: sample capture, state and settle timer share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tmr    <= '0;
      lft_q  <= '0;
      rght_q <= '0;
    end else begin
      state <= nxt_state;
      if (clr_tmr)                tmr <= '0;
      else if (inc_tmr && !(&tmr)) tmr <= tmr + 26'd1;
      if (ld_vld) begin
        lft_q  <= lft_ld;
        rght_q <= rght_ld;
      end
    end
  end

  assign en_steer  = (state == STEER_EN);
  assign rider_off = (state == IDLE);

endmodule

// File: doc/steer_en_sm.md
STEER_EN_SM -- requirements
Module: steer_en_sm

Interface
REQ-001 Parameter: FAST_SIM, default 0; when 1, the settle timer terminal count is shortened for full-chip simulation.
REQ-002 Parameter: MIN_RIDER_WT, default 12'h200; rider-present weight threshold, in load-cell counts.
REQ-003 Parameter: WT_HYST, default 12'h040; hysteresis applied around MIN_RIDER_WT.
REQ-004 Port: clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
REQ-006 Port: lft_ld  input  12  left load-cell reading from the A2D interface, unsigned.
REQ-007 Port: rght_ld  input  12  right load-cell reading from the A2D interface, unsigned.
REQ-008 Port: ld_vld  input  1  single-cycle strobe; lft_ld and rght_ld are valid in the same cycle.
REQ-009 Port: en_steer  output  1  steering enable to the balance controller.
REQ-010 Port: rider_off  output  1  high when no rider is present; drives the authentication block and the balance integrator clear.

Function
REQ-011 Capture: on a clk edge with ld_vld=1, the block SHALL load lft_ld and rght_ld into lft_q and rght_q. Without ld_vld, lft_q and rght_q hold their values.
REQ-012 Evaluation: all comparisons SHALL use lft_q and rght_q only; raw inputs never feed the FSM directly.
REQ-013 Sum: sum = lft_q + rght_q, 13-bit unsigned, no truncation.
REQ-014 Difference: diff = lft_q - rght_q, 13-bit signed; abs_diff = |diff|, 12-bit unsigned.
REQ-015 Rider-on compare: sum_gt_min = (sum > MIN_RIDER_WT + WT_HYST), strict.
REQ-016 Rider-off compare: sum_lt_min = (sum < MIN_RIDER_WT - WT_HYST), strict; inside the hysteresis band both compares are 0.
REQ-017 Quarter compare: diff_gt_1_4 = (abs_diff > sum>>2).
REQ-018 Fifteen-sixteenths compare: diff_gt_15_16 = (abs_diff > sum - (sum>>4)); compute at 13 bits, no overflow.
REQ-019 Settle timer: 26-bit up-counter, tmr.
  - tmr_full = &tmr[25:0] when FAST_SIM=0; &tmr[14:0] when FAST_SIM=1.
  - Counts +1 per clk in WAIT; cleared whenever the FSM requests clr_tmr; holds elsewhere.
  - Saturates at all-ones, never wraps.
REQ-020 FSM: three states, IDLE, WAIT and STEER_EN; outputs are Moore outputs decoded from the state register only.
REQ-021 Output decode:
  - IDLE: en_steer=0, rider_off=1.
  - WAIT: en_steer=0, rider_off=0.
  - STEER_EN: en_steer=1, rider_off=0.
REQ-022 IDLE transitions: if sum_gt_min, go to WAIT and clr_tmr; otherwise stay.
REQ-023 WAIT transitions, in priority order:
  - sum_lt_min: go to IDLE.
  - diff_gt_1_4: stay in WAIT and clr_tmr.
  - tmr_full: go to STEER_EN.
  - otherwise: stay and count.
REQ-024 STEER_EN transitions, in priority order:
  - sum_lt_min: go to IDLE.
  - diff_gt_15_16: go to WAIT and clr_tmr.
  - otherwise: stay.
REQ-025 Latency: an ld_vld sample that causes a transition SHALL change the outputs exactly 2 clk edges after the ld_vld edge (capture edge, then state edge).
REQ-026 Simultaneous events: sum_lt_min SHALL override every other condition in every state.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-028 With rst=1 at a clk edge, the block SHALL set: state=IDLE, tmr=0, lft_q=0, rght_q=0, en_steer=0, rider_off=1.
REQ-029 Reset asserted in any state mid-operation SHALL take effect on that edge and override ld_vld and all transitions.
REQ-030 After rst deasserts, the FSM SHALL stay in IDLE until a captured sample satisfies sum_gt_min.

Verification
REQ-031 Rider steps on, balanced, FAST_SIM=1: rst, then lft=rght=12'h180 strobed (sum 0x300).
  - Expected: rider_off falls 2 edges after the strobe.
  - Expected: en_steer rises 32767 clocks later.
REQ-032 Hysteresis band: from STEER_EN, strobe lft=rght=12'h0F0 (sum 0x1E0, inside band).
  - Expected: state holds STEER_EN.
  - Then strobe sum=0x1BE (lft=12'h0DF, rght=12'h0DF).
  - Expected: IDLE, rider_off=1, en_steer=0.
REQ-033 Lean during settle: in WAIT with tmr=1000, strobe lft=12'h300, rght=12'h100 (abs_diff 0x200 > 0x100).
  - Expected: tmr cleared, state holds WAIT.
  - Then strobe a balanced sample.
  - Expected: full count restarts from 0 before STEER_EN.
REQ-034 Heavy lean while steering: in STEER_EN, strobe lft=12'h3F8, rght=12'h008.
  - abs_diff 0x3F0 > sum - sum>>4 = 0x3C0.
  - Expected: WAIT, en_steer=0.
  - Also: lft=12'h300, rght=12'h100 keeps STEER_EN.
REQ-035 Simultaneous events: in WAIT, strobe a sample with sum 0x100 and a large imbalance, at the cycle where tmr_full=1.
  - Expected: IDLE, not STEER_EN.
REQ-036 Reset mid-operation: assert rst for 1 clk while in STEER_EN with ld_vld=1.
  - Expected: next edge en_steer=0, rider_off=1, tmr=0, lft_q=rght_q=0.
  - Strobe ignored.
